// File: rtl/macro_credit_cnt4.sv
// Credit counter for the issuing end of a credit-based link.
// Hands credits to a local requester, takes back credits returned by the
// remote consumer, and traps overflow/underflow in a sticky FAULT state.
// The +/-1 arithmetic goes through a small 4-bit increment/decrement ROM.

// Unsigned 4-bit increment/decrement lookup.
// Address is {dec, a}; the entry holds {carry/borrow, result}.
module macro_rom_decinc4 (
    input  logic [3:0] a,
    input  logic       dec,
    output logic [3:0] y,
    output logic       c
);
    logic [4:0] rom [0:31];

    // Table contents are constants elaborated per entry:
    // entries 0..15 hold a+1, entries 16..31 hold a-1 with borrow on 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rom
            if (gi < 16) begin : g_inc
                assign rom[gi] = 5'(gi + 1);
            end else if (gi == 16) begin : g_dec_zero
                assign rom[gi] = 5'b1_1111;
            end else begin : g_dec
                assign rom[gi] = 5'(gi - 17);
            end
        end
    endgenerate

    assign {c, y} = rom[{dec, a}];
endmodule

module macro_credit_cnt4 #(
    parameter int INIT_CREDITS = 8,
    parameter int MAX_CREDITS  = 15,
    parameter int BYPASS_ZERO  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       grant,
    input  logic       ret,
    output logic [3:0] credits,
    output logic       empty,
    output logic       full,
    output logic       ready,
    output logic       fault
);
    localparam logic [3:0] INIT4 = 4'(INIT_CREDITS);
    localparam logic [3:0] MAX4  = 4'(MAX_CREDITS);
    localparam logic       BYP   = (BYPASS_ZERO != 0);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] credits_reg, credits_next;
    logic       rom_dec;
    logic [3:0] rom_y;
    logic       rom_c;

    // A transfer with no matching return decrements; anything else asks the
    // ROM for the increment, which is only applied on a lone return.
    assign rom_dec = grant & ~ret;

    macro_rom_decinc4 u_rom (
        .a   (credits_reg),
        .dec (rom_dec),
        .y   (rom_y),
        .c   (rom_c)
    );

    // Next-state, next-count and the combinational grant.
    always_comb begin
        state_next   = state_reg;
        credits_next = credits_reg;
        grant        = 1'b0;
        case (state_reg)
            ST_INIT: begin
                state_next   = ST_RUN;
                credits_next = INIT4;
            end
            ST_RUN: begin
                grant = req & ((credits_reg != 4'd0) | (BYP & ret));
                if (grant && !ret) begin
                    // Borrow out of the ROM means a decrement from zero;
                    // the grant rule should prevent it, but trap it anyway.
                    if (rom_c) begin
                        state_next = ST_FAULT;
                    end else begin
                        credits_next = rom_y;
                    end
                end else if (ret && !grant) begin
                    // A return at the ceiling is an overflow: freeze at MAX.
                    if (credits_reg == MAX4 || rom_c) begin
                        state_next = ST_FAULT;
                    end else begin
                        credits_next = rom_y;
                    end
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next   = ST_INIT;
                credits_next = 4'd0;
            end
        endcase
    end

    // State and count registers; reset wins over any in-flight transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_INIT;
            credits_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            credits_reg <= credits_next;
        end
    end

    assign credits = credits_reg;
    assign empty   = (credits_reg == 4'd0);
    assign full    = (credits_reg == MAX4);
    assign ready   = (state_reg == ST_RUN);
    assign fault   = (state_reg == ST_FAULT);
endmodule

// File: tb/tb_macro_credit_cnt4.sv
// Bench for macro_credit_cnt4: three instances (default, no zero-bypass,
// INIT=MAX=15) share one stimulus stream. A behavioural model per instance
// pushes expected outputs at drive time; they are popped and compared at
// the following falling edge.
module tb_macro_credit_cnt4;
    logic clk = 1'b0;
    logic reset, req, ret;

    logic       grant_a, empty_a, full_a, ready_a, fault_a;
    logic       grant_b, empty_b, full_b, ready_b, fault_b;
    logic       grant_c, empty_c, full_c, ready_c, fault_c;
    logic [3:0] credits_a, credits_b, credits_c;

    always #5 clk = ~clk;

    macro_credit_cnt4 u_a (
        .clk(clk), .reset(reset), .req(req), .grant(grant_a), .ret(ret),
        .credits(credits_a), .empty(empty_a), .full(full_a),
        .ready(ready_a), .fault(fault_a)
    );

    macro_credit_cnt4 #(.INIT_CREDITS(8), .MAX_CREDITS(15), .BYPASS_ZERO(0)) u_b (
        .clk(clk), .reset(reset), .req(req), .grant(grant_b), .ret(ret),
        .credits(credits_b), .empty(empty_b), .full(full_b),
        .ready(ready_b), .fault(fault_b)
    );

    macro_credit_cnt4 #(.INIT_CREDITS(15), .MAX_CREDITS(15), .BYPASS_ZERO(1)) u_c (
        .clk(clk), .reset(reset), .req(req), .grant(grant_c), .ret(ret),
        .credits(credits_c), .empty(empty_c), .full(full_c),
        .ready(ready_c), .fault(fault_c)
    );

    typedef struct {
        int         inst;
        logic       chk_grant;
        logic       grant;
        logic [3:0] credits;
        logic       empty;
        logic       full;
        logic       ready;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Model state per instance: 0 INIT, 1 RUN, 2 FAULT
    int m_st  [3];
    int m_cnt [3];
    int p_init[3] = '{8, 8, 15};
    int p_max [3] = '{15, 15, 15};
    int p_byp [3] = '{1, 0, 1};

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, obs, exp_v);
        end
    endtask

    function automatic logic model_grant(input int i, input logic rq, input logic rt);
        return (m_st[i] == 1) && rq && (m_cnt[i] != 0 || (p_byp[i] != 0 && rt));
    endfunction

    task automatic model_step(input int i, input logic rs, input logic rq, input logic rt);
        logic g;
        g = model_grant(i, rq, rt);
        if (rs) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end else if (m_st[i] == 0) begin
            m_st[i]  = 1;
            m_cnt[i] = p_init[i];
        end else if (m_st[i] == 1) begin
            if (g && !rt) begin
                if (m_cnt[i] == 0) m_st[i] = 2;
                else m_cnt[i] = m_cnt[i] - 1;
            end else if (rt && !g) begin
                if (m_cnt[i] == p_max[i]) m_st[i] = 2;
                else m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    // One clock of stimulus: drive, push expectations, compare, advance model.
    task automatic step(input logic rs, input logic rq, input logic rt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs;
        req   = rq;
        ret   = rt;
        for (int i = 0; i < 3; i++) begin
            e.inst      = i;
            e.chk_grant = ~rs;
            e.grant     = model_grant(i, rq, rt);
            e.credits   = 4'(m_cnt[i]);
            e.empty     = (m_cnt[i] == 0);
            e.full      = (m_cnt[i] == p_max[i]);
            e.ready     = (m_st[i] == 1);
            e.fault     = (m_st[i] == 2);
            exp_q.push_back(e);
        end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.inst)
                0: begin
                    if (e.chk_grant) check("a.grant", int'(grant_a), int'(e.grant));
                    check("a.credits", int'(credits_a), int'(e.credits));
                    check("a.empty", int'(empty_a), int'(e.empty));
                    check("a.full", int'(full_a), int'(e.full));
                    check("a.ready", int'(ready_a), int'(e.ready));
                    check("a.fault", int'(fault_a), int'(e.fault));
                end
                1: begin
                    if (e.chk_grant) check("b.grant", int'(grant_b), int'(e.grant));
                    check("b.credits", int'(credits_b), int'(e.credits));
                    check("b.empty", int'(empty_b), int'(e.empty));
                    check("b.full", int'(full_b), int'(e.full));
                    check("b.ready", int'(ready_b), int'(e.ready));
                    check("b.fault", int'(fault_b), int'(e.fault));
                end
                default: begin
                    if (e.chk_grant) check("c.grant", int'(grant_c), int'(e.grant));
                    check("c.credits", int'(credits_c), int'(e.credits));
                    check("c.empty", int'(empty_c), int'(e.empty));
                    check("c.full", int'(full_c), int'(e.full));
                    check("c.ready", int'(ready_c), int'(e.ready));
                    check("c.fault", int'(fault_c), int'(e.fault));
                end
            endcase
        end
        $display("cycle=%0d rst=%0b req=%0b ret=%0b | a: g=%0b cr=%0d st=%0d | b: g=%0b cr=%0d st=%0d | c: g=%0b cr=%0d st=%0d",
                 cycle, rs, rq, rt, grant_a, credits_a, m_st[0],
                 grant_b, credits_b, m_st[1], grant_c, credits_c, m_st[2]);
        for (int i = 0; i < 3; i++) model_step(i, rs, rq, rt);
        cycle++;
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        ret   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
        // Initial reset: DUT state is unknown before the first edge, so the
        // first step only establishes it (its values are overwritten below).
        @(posedge clk);
        #1;
        // Reset again with checking; INIT values expected after this edge.
        step(1'b1, 1'b0, 1'b0);
        // INIT cycle, then RUN with the initial credit load.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Drain: nine requests (a/b run dry after eight).
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0);
        // Zero-bypass case: request and return together at zero.
        step(1'b0, 1'b1, 1'b1);
        // Returns to refill (a reaches 5).
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
        // Simultaneous request/return for ten cycles: counts hold.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
        // Lone returns push c (and later a, b) over the ceiling.
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);
        // Request after overflow: c must not grant.
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        // Reset out of FAULT, then reload.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Bring a to 3 and reset with a request in flight.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Random traffic, biased toward requests.
        for (int k = 0; k < 60; k++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
